// File: rtl/intirvx_alu_v2_pkg.sv
// Shared types for the intirvx integer ALU: decode bus, sub-unit/select
// encodings and the serial-shift FSM state.
package intirvx_alu_v2_pkg;

   // Default datapath width of the core.
   localparam int CPU_XLEN = 32;

   typedef enum logic [2:0] {
      SU_UPPER  = 3'd0,
      SU_BRANCH = 3'd1,
      SU_ADDSUB = 3'd2,
      SU_CMPLOG = 3'd3,
      SU_SHIFT  = 3'd4
   } alu_sub_unit_e;

   typedef enum logic [3:0] {
      UJ_LUI   = 4'd0,
      UJ_AUIPC = 4'd1,
      UJ_JAL   = 4'd2,
      UJ_JALR  = 4'd3
   } alu_upper_sel_e;

   typedef enum logic [3:0] {
      BR_BEQ  = 4'd0,
      BR_BNE  = 4'd1,
      BR_BLT  = 4'd2,
      BR_BGE  = 4'd3,
      BR_BLTU = 4'd4,
      BR_BGEU = 4'd5
   } alu_branch_sel_e;

   typedef enum logic [3:0] {
      AS_ADD = 4'd0,
      AS_SUB = 4'd1
   } alu_addsub_sel_e;

   typedef enum logic [3:0] {
      CL_SLT  = 4'd0,
      CL_SLTU = 4'd1,
      CL_XOR  = 4'd2,
      CL_OR   = 4'd3,
      CL_AND  = 4'd4
   } alu_cmplog_sel_e;

   typedef enum logic [3:0] {
      SH_SLL = 4'd0,
      SH_SRL = 4'd1,
      SH_SRA = 4'd2
   } alu_shift_sel_e;

   // Issue-side decode fields; sub_unit/sel are kept as raw bits so that
   // undefined encodings can be carried and turned into no-ops.
   typedef struct packed {
      logic [1:0] unit;
      logic [2:0] sub_unit;
      logic [3:0] sel;
      logic       imm;
   } decode_bus_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } alu_state_e;

   // True for the select codes the shift sub-unit implements.
   function automatic logic is_shift_sel(input logic [3:0] sel);
      return (sel <= SH_SRA);
   endfunction

endpackage

// File: rtl/intirvx_alu_serial_shifter.sv
// Iterative shifter: loads an operand and shift amount, moves one bit per
// cycle, and flags the final step so the caller can enqueue the result
// that is presented combinationally on that same cycle.
module intirvx_alu_serial_shifter
   import intirvx_alu_v2_pkg::*;
#(
   parameter int XLEN = CPU_XLEN
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_abort,
   input  logic                     i_start,
   input  logic [3:0]               i_op,
   input  logic [XLEN-1:0]          i_data,
   input  logic [$clog2(XLEN)-1:0]  i_shamt,
   output logic                     o_done,
   output logic [XLEN-1:0]          o_result
);

   localparam int SHW = $clog2(XLEN);
   localparam logic [SHW-1:0] C_ONE = {{(SHW-1){1'b0}}, 1'b1};

   logic [SHW-1:0]  r_cnt;
   logic [XLEN-1:0] r_val;
   logic [3:0]      r_op;

   // One-bit step of the selected shift; SRA keeps the sign bit.
   function automatic logic [XLEN-1:0] shift_one(input logic [3:0] op,
                                                 input logic [XLEN-1:0] v);
      case (op)
         SH_SLL:  shift_one = {v[XLEN-2:0], 1'b0};
         SH_SRL:  shift_one = {1'b0, v[XLEN-1:1]};
         SH_SRA:  shift_one = {v[XLEN-1], v[XLEN-1:1]};
         default: shift_one = v;
      endcase
   endfunction

   // Counter and shift register: load on start, step while count is non-zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_val <= '0;
         r_op  <= 4'd0;
      end else if (i_abort) begin
         r_cnt <= '0;
      end else if (i_start) begin
         r_cnt <= i_shamt;
         r_val <= i_data;
         r_op  <= i_op;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - C_ONE;
         r_val <= shift_one(r_op, r_val);
      end
   end

   // The last step's output is taken directly so no extra cycle is spent.
   assign o_done   = (r_cnt == C_ONE);
   assign o_result = shift_one(r_op, r_val);

endmodule

// File: rtl/intirvx_alu_v2.sv
// Integer ALU: executes unit-0 instructions from the register manager and
// queues results (write-back data, rd, jump redirect) in a small FIFO.
// Shifts are either single-cycle or iterative; an iterative shift reserves
// its queue slot on entry so its final enqueue can never stall.
module intirvx_alu_v2
   import intirvx_alu_v2_pkg::*;
#(
   parameter int XLEN         = CPU_XLEN,
   parameter int DEPTH        = 2,
   parameter int SHIFT_SERIAL = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  decode_bus_t      regman_decode,
   input  logic [XLEN-1:0]  regman_pc,
   input  logic [XLEN-1:0]  regman_rs1,
   input  logic [XLEN-1:0]  regman_rs2,
   input  logic [4:0]       regman_rd,
   input  logic [XLEN-1:0]  regman_imm,
   input  logic             regman_valid,
   output logic             regman_ready,
   output logic [XLEN-1:0]  alu_result,
   output logic [4:0]       alu_rd,
   output logic             alu_jump,
   output logic [XLEN-1:0]  alu_jump_addr,
   output logic             alu_valid,
   input  logic             alu_ready,
   input  logic             flush
);

   localparam int SHW  = $clog2(XLEN);
   localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTW = $clog2(DEPTH + 1);
   localparam logic [XLEN-1:0] C_FOUR  = {{(XLEN-3){1'b0}}, 3'b100};
   localparam logic [XLEN-1:0] C_ALIGN = {{(XLEN-1){1'b1}}, 1'b0};
   localparam logic [CNTW-1:0] C_DEPTH = CNTW'(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] res;
      logic [4:0]      rd;
      logic            jump;
      logic [XLEN-1:0] jump_addr;
   } alu_entry_t;

   alu_state_e       r_state, w_state_next;
   alu_entry_t       r_mem [DEPTH];
   logic [PTRW-1:0]  r_wptr, r_rptr;
   logic [CNTW-1:0]  r_count;
   logic [4:0]       r_shift_rd;

   logic [XLEN-1:0]  w_opb, w_res, w_addr, w_shift_res;
   logic             w_jump, w_taken, w_full, w_accept, w_exec;
   logic             w_start_serial, w_enq, w_deq, w_shift_done;
   alu_entry_t       w_entry;

   function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
      return (p == PTRW'(DEPTH - 1)) ? '0 : p + {{(PTRW-1){1'b0}}, 1'b1};
   endfunction

   assign w_opb = (regman_decode.imm && (regman_decode.sub_unit != SU_BRANCH))
                  ? regman_imm : regman_rs2;

   // Combinational result, branch decision and redirect target.
   always_comb begin
      w_res   = '0;
      w_jump  = 1'b0;
      w_addr  = '0;
      w_taken = 1'b0;
      case (regman_decode.sub_unit)
         SU_UPPER: begin
            case (regman_decode.sel)
               UJ_LUI:   w_res = regman_imm;
               UJ_AUIPC: w_res = regman_pc + regman_imm;
               UJ_JAL:   w_res = regman_pc + C_FOUR;
               UJ_JALR: begin
                  w_res  = regman_pc + C_FOUR;
                  w_jump = 1'b1;
                  w_addr = (regman_rs1 + regman_imm) & C_ALIGN;
               end
               default:  w_res = '0;
            endcase
         end
         SU_BRANCH: begin
            case (regman_decode.sel)
               BR_BEQ:  w_taken = (regman_rs1 == regman_rs2);
               BR_BNE:  w_taken = (regman_rs1 != regman_rs2);
               BR_BLT:  w_taken = ($signed(regman_rs1) <  $signed(regman_rs2));
               BR_BGE:  w_taken = ($signed(regman_rs1) >= $signed(regman_rs2));
               BR_BLTU: w_taken = (regman_rs1 <  regman_rs2);
               BR_BGEU: w_taken = (regman_rs1 >= regman_rs2);
               default: w_taken = 1'b0;
            endcase
            if (w_taken) begin
               w_jump = 1'b1;
               w_addr = regman_pc + regman_imm;
            end else begin
               w_jump = 1'b0;
               w_addr = '0;
            end
         end
         SU_ADDSUB: begin
            case (regman_decode.sel)
               AS_ADD:  w_res = regman_rs1 + w_opb;
               AS_SUB:  w_res = regman_rs1 - regman_rs2;
               default: w_res = '0;
            endcase
         end
         SU_CMPLOG: begin
            case (regman_decode.sel)
               CL_SLT:  w_res = {{(XLEN-1){1'b0}}, ($signed(regman_rs1) < $signed(w_opb))};
               CL_SLTU: w_res = {{(XLEN-1){1'b0}}, (regman_rs1 < w_opb)};
               CL_XOR:  w_res = regman_rs1 ^ w_opb;
               CL_OR:   w_res = regman_rs1 | w_opb;
               CL_AND:  w_res = regman_rs1 & w_opb;
               default: w_res = '0;
            endcase
         end
         SU_SHIFT: begin
            case (regman_decode.sel)
               SH_SLL:  w_res = regman_rs1 << w_opb[SHW-1:0];
               SH_SRL:  w_res = regman_rs1 >> w_opb[SHW-1:0];
               SH_SRA:  w_res = $signed(regman_rs1) >>> w_opb[SHW-1:0];
               default: w_res = '0;
            endcase
         end
         default: w_res = '0;
      endcase
   end

   // The reservation held during an iterative shift counts as occupancy.
   assign w_full       = ((r_count + CNTW'(r_state == ST_SHIFT)) >= C_DEPTH);
   assign regman_ready = (r_state == ST_IDLE) && !w_full;
   assign w_accept     = regman_valid && regman_ready;
   assign w_exec       = w_accept && (regman_decode.unit == 2'd0) && !flush;

   assign w_start_serial = (SHIFT_SERIAL != 0) && w_exec
                           && (regman_decode.sub_unit == SU_SHIFT)
                           && is_shift_sel(regman_decode.sel)
                           && (w_opb[SHW-1:0] != '0);

   generate
      if (SHIFT_SERIAL != 0) begin : g_serial
         intirvx_alu_serial_shifter #(.XLEN(XLEN)) u_shifter (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_abort  (flush),
            .i_start  (w_start_serial),
            .i_op     (regman_decode.sel),
            .i_data   (regman_rs1),
            .i_shamt  (w_opb[SHW-1:0]),
            .o_done   (w_shift_done),
            .o_result (w_shift_res)
         );
      end else begin : g_comb
         assign w_shift_done = 1'b0;
         assign w_shift_res  = '0;
      end
   endgenerate

   // Shift FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Shift FSM next state; flush always returns to IDLE.
   always_comb begin
      w_state_next = r_state;
      if (flush) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  w_state_next = w_start_serial ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: w_state_next = w_shift_done   ? ST_IDLE  : ST_SHIFT;
            default:  w_state_next = ST_IDLE;
         endcase
      end
   end

   // Destination register of the shift in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift_rd <= 5'd0;
      end else if (w_start_serial) begin
         r_shift_rd <= regman_rd;
      end
   end

   assign w_enq = (w_exec && !w_start_serial) || (w_shift_done && (r_state == ST_SHIFT));
   assign w_deq = (r_count != '0) && alu_ready;

   always_comb begin
      w_entry = '0;
      if (w_shift_done && (r_state == ST_SHIFT)) begin
         w_entry.res = w_shift_res;
         w_entry.rd  = r_shift_rd;
      end else begin
         w_entry.res       = w_res;
         w_entry.rd        = regman_rd;
         w_entry.jump      = w_jump;
         w_entry.jump_addr = w_addr;
      end
   end

   // Output queue storage, pointers and occupancy; flush empties it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_enq) begin
            r_mem[r_wptr] <= w_entry;
            r_wptr        <= ptr_inc(r_wptr);
         end
         if (w_deq) begin
            r_rptr <= ptr_inc(r_rptr);
         end
         r_count <= r_count + CNTW'(w_enq) - CNTW'(w_deq);
      end
   end

   assign alu_valid     = (r_count != '0);
   assign alu_result    = r_mem[r_rptr].res;
   assign alu_rd        = r_mem[r_rptr].rd;
   assign alu_jump      = r_mem[r_rptr].jump;
   assign alu_jump_addr = r_mem[r_rptr].jump_addr;

endmodule

// File: tb/tb_intirvx_alu_v2.sv
// Self-checking bench for intirvx_alu_v2 (XLEN=32, DEPTH=2, serial shifter).
// A reference model predicts each queued result from the instruction rules
// and tracks the output queue and shift busy time as a plain list plus a
// countdown; DUT outputs are compared every cycle at the falling edge.
module tb_intirvx_alu_v2;
   import intirvx_alu_v2_pkg::*;

   localparam int XLEN  = 32;
   localparam int DEPTH = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   decode_bus_t       dec;
   logic [XLEN-1:0]   pc, rs1, rs2, imm;
   logic [4:0]        rd;
   logic              regman_valid, regman_ready;
   logic [XLEN-1:0]   alu_result, alu_jump_addr;
   logic [4:0]        alu_rd;
   logic              alu_jump, alu_valid, alu_ready, flush;

   intirvx_alu_v2 #(.XLEN(XLEN), .DEPTH(DEPTH), .SHIFT_SERIAL(1)) dut (
      .clk(clk), .rst_n(rst_n), .regman_decode(dec), .regman_pc(pc),
      .regman_rs1(rs1), .regman_rs2(rs2), .regman_rd(rd), .regman_imm(imm),
      .regman_valid(regman_valid), .regman_ready(regman_ready),
      .alu_result(alu_result), .alu_rd(alu_rd), .alu_jump(alu_jump),
      .alu_jump_addr(alu_jump_addr), .alu_valid(alu_valid),
      .alu_ready(alu_ready), .flush(flush)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        jump;
      logic [31:0] addr;
   } exp_t;

   int n_cmp = 0;
   int n_mis = 0;

   // Staged instruction, applied to the DUT at the next falling edge.
   decode_bus_t s_dec;
   logic [31:0] s_pc, s_rs1, s_rs2, s_imm;
   logic [4:0]  s_rd;

   exp_t q[$];
   bit   busy = 1'b0;
   int   busy_left = 0;
   exp_t pend;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Result of one instruction from the ISA rules.
   function automatic exp_t ref_model(decode_bus_t d, logic [31:0] p, logic [31:0] a,
                                      logic [31:0] b, logic [31:0] im, logic [4:0] r);
      exp_t e;
      logic [31:0] ob;
      int sh;
      bit t;
      e.res = 32'd0; e.rd = r; e.jump = 1'b0; e.addr = 32'd0;
      t = 1'b0;
      ob = (d.imm && d.sub_unit != 3'd1) ? im : b;
      sh = ob % 32;
      case (d.sub_unit)
         3'd0: case (d.sel)
                  4'd0: e.res = im;
                  4'd1: e.res = p + im;
                  4'd2: e.res = p + 32'd4;
                  4'd3: begin e.res = p + 32'd4; e.jump = 1'b1; e.addr = (a + im) & 32'hFFFF_FFFE; end
                  default: e.res = 32'd0;
               endcase
         3'd1: begin
            case (d.sel)
               4'd0: t = (a == b);
               4'd1: t = (a != b);
               4'd2: t = ($signed(a) <  $signed(b));
               4'd3: t = ($signed(a) >= $signed(b));
               4'd4: t = (a <  b);
               4'd5: t = (a >= b);
               default: t = 1'b0;
            endcase
            if (t) begin e.jump = 1'b1; e.addr = p + im; end
         end
         3'd2: case (d.sel)
                  4'd0: e.res = a + ob;
                  4'd1: e.res = a - b;
                  default: e.res = 32'd0;
               endcase
         3'd3: case (d.sel)
                  4'd0: e.res = ($signed(a) < $signed(ob)) ? 32'd1 : 32'd0;
                  4'd1: e.res = (a < ob) ? 32'd1 : 32'd0;
                  4'd2: e.res = a ^ ob;
                  4'd3: e.res = a | ob;
                  4'd4: e.res = a & ob;
                  default: e.res = 32'd0;
               endcase
         3'd4: case (d.sel)
                  4'd0: e.res = a << sh;
                  4'd1: e.res = a >> sh;
                  4'd2: e.res = 32'($signed(a) >>> sh);
                  default: e.res = 32'd0;
               endcase
         default: e.res = 32'd0;
      endcase
      return e;
   endfunction

   task automatic set_op(input logic [2:0] su, input logic [3:0] sel, input logic ib,
                         input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [4:0] r);
      s_dec.unit = 2'd0; s_dec.sub_unit = su; s_dec.sel = sel; s_dec.imm = ib;
      s_pc = p; s_rs1 = a; s_rs2 = b; s_imm = im; s_rd = r;
   endtask

   // One cycle: compare outputs with the model, drive inputs, advance the model.
   task automatic step(input logic v, input logic ar, input logic fl);
      bit ev, er;
      exp_t e;
      logic [31:0] ob;
      @(negedge clk);
      ev = (q.size() != 0);
      er = !busy && (q.size() < DEPTH);
      check_value("alu_valid", {31'd0, alu_valid}, {31'd0, ev});
      check_value("regman_ready", {31'd0, regman_ready}, {31'd0, er});
      if (ev) begin
         check_value("alu_result", alu_result, q[0].res);
         check_value("alu_rd", {27'd0, alu_rd}, {27'd0, q[0].rd});
         check_value("alu_jump", {31'd0, alu_jump}, {31'd0, q[0].jump});
         check_value("alu_jump_addr", alu_jump_addr, q[0].addr);
      end
      dec = s_dec; pc = s_pc; rs1 = s_rs1; rs2 = s_rs2; imm = s_imm; rd = s_rd;
      regman_valid = v; alu_ready = ar; flush = fl;
      if (fl) begin
         q.delete();
         busy = 1'b0;
      end else begin
         if (ev && ar) void'(q.pop_front());
         if (busy) begin
            busy_left--;
            if (busy_left == 0) begin
               q.push_back(pend);
               busy = 1'b0;
            end
         end
         if (v && er && s_dec.unit == 2'd0) begin
            e  = ref_model(s_dec, s_pc, s_rs1, s_rs2, s_imm, s_rd);
            ob = s_dec.imm ? s_imm : s_rs2;
            if (s_dec.sub_unit == 3'd4 && s_dec.sel <= 4'd2 && ob[4:0] != 5'd0) begin
               busy = 1'b1; busy_left = int'(ob[4:0]); pend = e;
            end else begin
               q.push_back(e);
            end
         end
      end
   endtask

   task automatic peek();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state();
      check_value("rst_valid", {31'd0, alu_valid}, 32'd0);
      check_value("rst_ready", {31'd0, regman_ready}, 32'd1);
      check_value("rst_result", alu_result, 32'd0);
      check_value("rst_rd", {27'd0, alu_rd}, 32'd0);
      check_value("rst_jump", {31'd0, alu_jump}, 32'd0);
      check_value("rst_addr", alu_jump_addr, 32'd0);
   endtask

   function automatic logic [31:0] rnd_word();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      dec = '0; pc = 32'd0; rs1 = 32'd0; rs2 = 32'd0; imm = 32'd0; rd = 5'd0;
      regman_valid = 1'b0; alu_ready = 1'b1; flush = 1'b0;
      set_op(3'd2, 4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
      #23;
      check_reset_state();
      @(negedge clk);
      rst_n = 1'b1;

      // ADD overflow wraps; result visible one cycle after accept.
      set_op(3'd2, 4'd0, 1'b0, 32'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd5);
      step(1'b1, 1'b1, 1'b0); peek();
      check_value("add_valid_n1", {31'd0, alu_valid}, 32'd1);
      check_value("add_result", alu_result, 32'h8000_0000);
      check_value("add_rd", {27'd0, alu_rd}, 32'd5);
      // SUB ignores the immediate flag.
      set_op(3'd2, 4'd1, 1'b1, 32'd0, 32'd0, 32'd1, 32'h10, 5'd6);
      step(1'b1, 1'b1, 1'b0); peek();
      check_value("sub_result", alu_result, 32'hFFFF_FFFF);
      set_op(3'd3, 4'd0, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd7);
      step(1'b1, 1'b1, 1'b0); peek();
      check_value("slt_result", alu_result, 32'd1);
      set_op(3'd3, 4'd1, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd8);
      step(1'b1, 1'b1, 1'b0); peek();
      check_value("sltu_result", alu_result, 32'd0);
      set_op(3'd1, 4'd5, 1'b1, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 5'd9);
      step(1'b1, 1'b1, 1'b0); peek();
      check_value("bgeu_jump", {31'd0, alu_jump}, 32'd1);
      check_value("bgeu_addr", alu_jump_addr, 32'h240);
      check_value("bgeu_res", alu_result, 32'd0);
      set_op(3'd0, 4'd3, 1'b1, 32'h100, 32'h2001, 32'd0, 32'd2, 5'd10);
      step(1'b1, 1'b1, 1'b0); peek();
      check_value("jalr_res", alu_result, 32'h104);
      check_value("jalr_jump", {31'd0, alu_jump}, 32'd1);
      check_value("jalr_addr", alu_jump_addr, 32'h2002);

      // Serial SRA by 4: ready low for four cycles, valid on the fifth.
      set_op(3'd4, 4'd2, 1'b0, 32'd0, 32'h8000_0000, 32'd4, 32'd0, 5'd11);
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 1'b0);
         check_value("sra_busy_ready", {31'd0, regman_ready}, 32'd0);
         check_value("sra_busy_valid", {31'd0, alu_valid}, 32'd0);
      end
      step(1'b0, 1'b1, 1'b0);
      check_value("sra_valid_n5", {31'd0, alu_valid}, 32'd1);
      check_value("sra_result", alu_result, 32'hF800_0000);
      // Shift amount zero behaves as a single-cycle op.
      set_op(3'd4, 4'd2, 1'b0, 32'd0, 32'h8000_0000, 32'd0, 32'd0, 5'd12);
      step(1'b1, 1'b1, 1'b0); peek();
      check_value("sra0_valid_n1", {31'd0, alu_valid}, 32'd1);
      check_value("sra0_result", alu_result, 32'h8000_0000);
      step(1'b0, 1'b1, 1'b0);

      // Backpressure: two ADDs fill the queue, the third waits.
      set_op(3'd2, 4'd0, 1'b0, 32'd0, 32'd10, 32'd1, 32'd0, 5'd1);
      step(1'b1, 1'b0, 1'b0);
      set_op(3'd2, 4'd0, 1'b0, 32'd0, 32'd20, 32'd2, 32'd0, 5'd2);
      step(1'b1, 1'b0, 1'b0);
      set_op(3'd2, 4'd0, 1'b0, 32'd0, 32'd30, 32'd3, 32'd0, 5'd3);
      step(1'b1, 1'b0, 1'b0);
      check_value("bp_ready_full", {31'd0, regman_ready}, 32'd0);
      step(1'b1, 1'b0, 1'b0);
      check_value("bp_hold_result", alu_result, 32'd11);
      check_value("bp_hold_rd", {27'd0, alu_rd}, 32'd1);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);

      // Flush while shifting with the queue full (entry + reservation).
      set_op(3'd2, 4'd0, 1'b0, 32'd0, 32'd1, 32'd1, 32'd0, 5'd4);
      step(1'b1, 1'b0, 1'b0);
      set_op(3'd4, 4'd0, 1'b0, 32'd0, 32'd1, 32'd8, 32'd0, 5'd13);
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1); peek();
      check_value("flush_valid", {31'd0, alu_valid}, 32'd0);
      check_value("flush_ready", {31'd0, regman_ready}, 32'd1);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);

      // Reset in the middle of a shift.
      set_op(3'd4, 4'd1, 1'b0, 32'd0, 32'hFFFF_0000, 32'd10, 32'd0, 5'd14);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      regman_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_state();
      q.delete(); busy = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Randomised traffic, including other units, undefined selects and flushes.
      for (int n = 0; n < 800; n++) begin
         s_dec.unit     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         s_dec.sub_unit = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                                      : 3'($urandom_range(0, 4));
         s_dec.sel      = 4'($urandom_range(0, 7));
         s_dec.imm      = 1'($urandom_range(0, 1));
         s_pc  = rnd_word(); s_rs1 = rnd_word(); s_rs2 = rnd_word();
         s_imm = rnd_word(); s_rd  = 5'($urandom_range(0, 31));
         step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 7),
              1'($urandom_range(0, 24) == 0));
      end
      for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
